// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: parametrised width/depth, fixed wait states, stall
// injection, address-window ERROR response and byte-lane write strobes.
module ahb_slave_mem #(
  parameter int unsigned DATA_WDT    = 32,
  parameter int unsigned ADDR_WDT    = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_LO      = 32'hFFFF_FFFF,
  parameter logic [31:0] ERR_HI      = 32'hFFFF_FFFF
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  input  logic                i_stall,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp
);
  localparam int unsigned BYTES   = DATA_WDT / 8;
  localparam int unsigned OFF_WDT = $clog2(BYTES);
  localparam int unsigned DEPTH   = 1 << ADDR_WDT;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [ADDR_WDT-1:0] idx_q;
  logic [OFF_WDT-1:0]  off_q;
  logic                write_q;
  logic [2:0]          size_q;

  logic [DATA_WDT-1:0] mem [DEPTH];

  logic                accept;
  logic                addr_err;
  logic                data_done;
  logic [31:0]         size_bytes;
  logic [BYTES-1:0]    lane_en;
  logic                unused_ok;

  // Burst type and the SEQ/NONSEQ distinction do not matter: every beat carries its own address.
  assign unused_ok = ^{i_hburst, i_htrans[0]};

  assign accept     = i_hready & i_hsel & i_htrans[1];
  assign size_bytes = 32'd1 << i_hsize;
  assign addr_err   = ((i_haddr >= ERR_LO) && (i_haddr <= ERR_HI))
                   || (size_bytes > BYTES)
                   || ((i_haddr & (size_bytes - 32'd1)) != 32'd0);

  // pend_q marks an OKAY data phase in flight; it completes once the wait count is spent and no stall is applied.
  assign data_done = pend_q && (cnt_q == 4'd0) && !i_stall;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (pend_q && (cnt_q != 4'd0) && !i_stall)
          cnt_d = cnt_q - 4'd1;
        if (data_done || (state_q == ST_ERR2)) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          state_d = ST_WAIT;
        end
        if (accept) begin
          if (addr_err) begin
            state_d = ST_ERR1;
            pend_d  = 1'b0;
            cnt_d   = 4'd0;
          end else begin
            state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_IDLE;
            pend_d  = 1'b1;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (accept) begin
        idx_q   <= i_haddr[ADDR_WDT+OFF_WDT-1:OFF_WDT];
        off_q   <= i_haddr[OFF_WDT-1:0];
        write_q <= i_hwrite;
        size_q  <= i_hsize;
      end
    end
  end

  always_comb begin
    lane_en = '0;
    for (int i = 0; i < BYTES; i++)
      lane_en[i] = (i >= int'(off_q)) && (i < int'(off_q) + (1 << size_q));
  end

  // NOTE: the storage array has no reset; clearing it would turn the RAM into a flop bank.
  always_ff @(posedge i_hclk) begin
    if (data_done && write_q) begin
      for (int i = 0; i < BYTES; i++)
        if (lane_en[i])
          mem[idx_q][i*8 +: 8] <= i_hwdata[i*8 +: 8];
    end
  end

  assign o_hready = (state_q != ST_ERR1) && !(pend_q && ((cnt_q != 4'd0) || i_stall));
  assign o_hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
  assign o_hrdata = (pend_q && !write_q) ? mem[idx_q] : '0;
endmodule
